// File: rtl/tomasulo_harness_pkg.sv
// Shared types and default sizing for the Tomasulo run harness.
package tomasulo_harness_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int TIMEOUT_DEF    = 100000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DUMP,
    S_CHECK_LAST,
    S_FINISH
  } harness_state_e;
endpackage

// File: rtl/tomasulo_run_harness_if.sv
// Harness <-> core control and register-read bus.
interface tomasulo_run_harness_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  core_hold;
  logic                  core_done;
  logic [REG_ADDR_W-1:0] reg_addr;
  logic [XLEN-1:0]       reg_data;

  modport master (output core_hold, reg_addr, input core_done, reg_data);
  modport slave  (input core_hold, reg_addr, output core_done, reg_data);
endinterface

// File: rtl/harness_exp_table.sv
// Expected register values with per-entry valid bits; reset clears valids only.
module harness_exp_table #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int NUM_CHECK_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr,
  output logic [XLEN-1:0]       rdata,
  output logic                  rvalid
);
  logic [XLEN-1:0]           mem [NUM_CHECK_REGS];
  logic [NUM_CHECK_REGS-1:0] vld;
  logic                      wr_ok;

  assign wr_ok = we && (int'(waddr) < NUM_CHECK_REGS);

  always_ff @(posedge clk)
    if (wr_ok) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge reset)
    if (!reset)     vld <= '0;
    else if (wr_ok) vld[waddr] <= 1'b1;

  assign rdata  = mem[raddr];
  assign rvalid = (int'(raddr) < NUM_CHECK_REGS) && vld[raddr];
endmodule

// File: rtl/tomasulo_run_harness.sv
// Run controller: gates the core, watches for timeout, drains, dumps and
// checks architectural registers against the expected table.
module tomasulo_run_harness
  import tomasulo_harness_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
  parameter int NUM_CHECK_REGS = 32,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int DRAIN_CYCLES   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    exp_we,
  input  logic [REG_ADDR_W-1:0]   exp_addr,
  input  logic [XLEN-1:0]         exp_data,
  tomasulo_run_harness_if.master  core,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [REG_ADDR_W:0]     mismatch_count,
  output logic [REG_ADDR_W-1:0]   first_mismatch_addr
);
  localparam logic [REG_ADDR_W-1:0] LAST_IDX   = REG_ADDR_W'(NUM_CHECK_REGS - 1);
  localparam logic [CNT_W-1:0]      TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  harness_state_e        state, nxt;
  logic [CNT_W-1:0]      drain_cnt;
  logic [REG_ADDR_W-1:0] idx, cmp_idx;
  logic [XLEN-1:0]       cmp_data, exp_rd;
  logic                  cmp_vld, exp_rv, mis, can_load;
  logic [REG_ADDR_W:0]   mis_total;

  assign can_load  = (state == S_IDLE) || (state == S_FINISH);
  assign mis       = cmp_vld && exp_rv && (exp_rd != cmp_data);
  assign mis_total = mismatch_count + (REG_ADDR_W+1)'(mis);

  harness_exp_table #(
    .XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_CHECK_REGS(NUM_CHECK_REGS)
  ) u_exp (
    .clk(clk), .reset(reset),
    .we(exp_we && can_load), .waddr(exp_addr), .wdata(exp_data),
    .raddr(cmp_idx), .rdata(exp_rd), .rvalid(exp_rv)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_FINISH: if (start) nxt = S_RUN;
      // core_done wins over a coincident timeout
      S_RUN:
        if (core.core_done)            nxt = (DRAIN_CYCLES == 0) ? S_DUMP : S_DRAIN;
        else if (cycle_count == TO_LAST) nxt = S_FINISH;
      S_DRAIN:      if (drain_cnt == '0) nxt = S_DUMP;
      S_DUMP:       if (idx == LAST_IDX) nxt = S_CHECK_LAST;
      S_CHECK_LAST: nxt = S_FINISH;
      default:      nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core.core_hold = !((state == S_RUN) || (state == S_DRAIN));
    core.reg_addr  = (state == S_DUMP) ? idx : '0;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      drain_cnt           <= '0;
      idx                 <= '0;
      cmp_idx             <= '0;
      cmp_data            <= '0;
      cmp_vld             <= 1'b0;
      cycle_count         <= '0;
      mismatch_count      <= '0;
      first_mismatch_addr <= '0;
      done                <= 1'b0;
      pass                <= 1'b0;
      fail                <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      // one-stage compare pipe: capture (index, data) now, compare next cycle
      cmp_vld  <= (state == S_DUMP);
      cmp_idx  <= idx;
      cmp_data <= core.reg_data;
      case (state)
        S_IDLE, S_FINISH:
          if (start) begin
            cycle_count         <= '0;
            mismatch_count      <= '0;
            first_mismatch_addr <= '0;
            done                <= 1'b0;
            pass                <= 1'b0;
            fail                <= 1'b0;
            timeout             <= 1'b0;
          end
        S_RUN:
          if (core.core_done) begin
            drain_cnt <= DRAIN_LOAD;
            idx       <= '0;
          end else if (cycle_count == TO_LAST) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            fail    <= 1'b1;
          end else begin
            cycle_count <= cycle_count + 1'b1;
          end
        S_DRAIN:  if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
        S_DUMP:   idx <= idx + 1'b1;
        default: ;
      endcase
      if (mis) begin
        mismatch_count <= mis_total;
        if (mismatch_count == '0) first_mismatch_addr <= cmp_idx;
      end
      if (state == S_CHECK_LAST) begin
        done <= 1'b1;
        pass <= (mis_total == '0) && !timeout;
        fail <= !((mis_total == '0) && !timeout);
      end
    end
endmodule

// File: tb/tb_tomasulo_run_harness.sv
// Bench for tomasulo_run_harness: randomized core register contents and
// expected tables, results predicted from a table-level model.
module tb_tomasulo_run_harness;
  localparam int NREG = 24;
  localparam int TO   = 200;
  localparam int DRN  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start = 1'b0, exp_we = 1'b0, core_done = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        done, pass, fail, timeout;
  logic [31:0] cycle_count;
  logic [5:0]  mismatch_count;
  logic [4:0]  first_mismatch_addr;

  logic [31:0] core_regs [32];
  logic [31:0] exp_m [32];
  bit          exp_v [32];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  tomasulo_run_harness_if #(.XLEN(32), .REG_ADDR_W(5)) cif ();
  assign cif.core_done = core_done;
  assign cif.reg_data  = core_regs[cif.reg_addr];

  tomasulo_run_harness #(
    .XLEN(32), .REG_ADDR_W(5), .NUM_CHECK_REGS(NREG), .CNT_W(32),
    .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DRN)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .core(cif),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .cycle_count(cycle_count), .mismatch_count(mismatch_count),
    .first_mismatch_addr(first_mismatch_addr)
  );

  task automatic model_clear();
    for (int i = 0; i < 32; i++) exp_v[i] = 1'b0;
  endtask

  task automatic fill_garbage();
    for (int i = 0; i < 32; i++) core_regs[i] = $urandom;
  endtask

  // only called while the harness is in IDLE or FINISH
  task automatic write_exp(input int a, input logic [31:0] d);
    @(negedge clk);
    exp_we = 1'b1; exp_addr = a[4:0]; exp_data = d;
    @(negedge clk);
    exp_we = 1'b0;
    if (a < NREG) begin exp_m[a] = d; exp_v[a] = 1'b1; end
  endtask

  function automatic void model_expect(output int cnt, output int first);
    cnt = 0; first = 0;
    for (int i = 0; i < NREG; i++)
      if (exp_v[i] && exp_m[i] !== core_regs[i]) begin
        if (cnt == 0) first = i;
        cnt++;
      end
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; start = 1'b0; exp_we = 1'b0; core_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Start a run; the core model raises core_done for the RUN cycle whose
  // index is done_at (-1 = never). Returns DRAIN length seen and max reg_addr.
  task automatic run(input int done_at, input bit inject, output int hold_low,
                     output int max_addr, output bit finished);
    int c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (cycle_count !== 32'd0 || done !== 1'b0 || cif.core_hold !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: cycle_count=%0d done=%b core_hold=%b, required 0/0/0",
               cycle_count, done, cif.core_hold);
    end
    hold_low = 0; max_addr = 0; finished = 1'b0; c = 0;
    while (!finished && c < 600) begin
      core_done = (c == done_at);
      if (inject && c == 1) begin
        exp_we = 1'b1; exp_addr = 5'd3; exp_data = ~core_regs[3];
      end else if (inject && c == 2) exp_we = 1'b0;
      if (done_at >= 0 && c > done_at && cif.core_hold === 1'b0) hold_low++;
      if (int'(cif.reg_addr) > max_addr) max_addr = int'(cif.reg_addr);
      if (done === 1'b1) finished = 1'b1;
      else begin @(negedge clk); c++; end
    end
    core_done = 1'b0; exp_we = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL run_bound: done still %b after 600 cycles, required 1", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; #1; reset = 1'b0; #2;
    checks++;
    if ({done, pass, fail, timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b, required 0000", {done, pass, fail, timeout});
    end
    checks++;
    if (cycle_count !== 32'd0 || mismatch_count !== 6'd0 || first_mismatch_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_counts: cyc=%0d mis=%0d first=%0d, required 0/0/0",
               cycle_count, mismatch_count, first_mismatch_addr);
    end
    checks++;
    if (cif.core_hold !== 1'b1 || cif.reg_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_core: hold=%b reg_addr=%0d, required 1/0", cif.core_hold, cif.reg_addr);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
  endtask

  task automatic test_pass();
    int hl, ma, cnt, first; bit fin;
    fill_garbage();
    write_exp(1, 32'd5); write_exp(2, 32'd10); write_exp(3, 32'd15);
    core_regs[1] = 32'd5; core_regs[2] = 32'd10; core_regs[3] = 32'd15;
    run(40, 1'b0, hl, ma, fin);
    model_expect(cnt, first);
    checks++;
    if ({done, pass, fail, timeout} !== {1'b1, cnt == 0, cnt != 0, 1'b0}) begin
      errors++; $display("FAIL pass_flags: got %b, required %b", {done, pass, fail, timeout},
                         {1'b1, cnt == 0, cnt != 0, 1'b0});
    end
    checks++;
    if (cycle_count !== 32'd40 || mismatch_count !== 6'(cnt)) begin
      errors++; $display("FAIL pass_counts: cyc=%0d mis=%0d, required 40/%0d",
                         cycle_count, mismatch_count, cnt);
    end
    checks++;
    if (hl !== DRN) begin
      errors++; $display("FAIL pass_drain: drain cycles %0d, required %0d", hl, DRN);
    end
    checks++;
    if (ma !== NREG - 1 || cif.core_hold !== 1'b1) begin
      errors++; $display("FAIL pass_dump: max reg_addr=%0d hold=%b, required %0d/1", ma,
                         cif.core_hold, NREG - 1);
    end
  endtask

  task automatic test_back_to_back();
    int hl, ma; bit fin;
    run(25, 1'b0, hl, ma, fin);
    checks++;
    if ({done, pass, fail} !== 3'b110 || cycle_count !== 32'd25) begin
      errors++; $display("FAIL b2b_result: flags=%b cyc=%0d, required 110/25",
                         {done, pass, fail}, cycle_count);
    end
  endtask

  task automatic test_mismatch();
    int hl, ma, cnt, first; bit fin;
    core_regs[2] = 32'd11; core_regs[3] = 32'd0;
    run(40, 1'b0, hl, ma, fin);
    model_expect(cnt, first);
    checks++;
    if ({done, pass, fail, timeout} !== 4'b1010) begin
      errors++; $display("FAIL mis_flags: got %b, required 1010", {done, pass, fail, timeout});
    end
    checks++;
    if (mismatch_count !== 6'(cnt) || first_mismatch_addr !== 5'(first)) begin
      errors++; $display("FAIL mis_counts: mis=%0d first=%0d, required %0d/%0d",
                         mismatch_count, first_mismatch_addr, cnt, first);
    end
  endtask

  task automatic test_timeout();
    int hl, ma; bit fin;
    run(-1, 1'b0, hl, ma, fin);
    checks++;
    if ({done, pass, fail, timeout} !== 4'b1011) begin
      errors++; $display("FAIL to_flags: got %b, required 1011", {done, pass, fail, timeout});
    end
    checks++;
    if (cycle_count !== 32'(TO - 1) || mismatch_count !== 6'd0) begin
      errors++; $display("FAIL to_counts: cyc=%0d mis=%0d, required %0d/0",
                         cycle_count, mismatch_count, TO - 1);
    end
    checks++;
    if (ma !== 0) begin
      errors++; $display("FAIL to_nodump: max reg_addr=%0d, required 0", ma);
    end
  endtask

  task automatic test_sparse();
    int hl, ma; bit fin;
    apply_reset();
    fill_garbage();
    write_exp(7, core_regs[7]);
    run(30, 1'b1, hl, ma, fin);
    checks++;
    if ({done, pass, fail} !== 3'b110 || mismatch_count !== 6'd0) begin
      errors++; $display("FAIL sparse_result: flags=%b mis=%0d, required 110/0",
                         {done, pass, fail}, mismatch_count);
    end
  endtask

  task automatic test_reset_mid_dump();
    int c, hl, ma; bit hit, fin;
    apply_reset();
    fill_garbage();
    write_exp(1, core_regs[1]); write_exp(2, ~core_regs[2]); write_exp(3, core_regs[3]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0; hit = 1'b0;
    while (!hit && c < 300) begin
      core_done = (c == 5);
      if (cif.reg_addr === 5'd12) hit = 1'b1;
      else begin @(negedge clk); c++; end
    end
    core_done = 1'b0;
    checks++;
    if (!hit || mismatch_count !== 6'd1) begin
      errors++; $display("FAIL mid_dump: reached=%b mis=%0d, required 1/1", hit, mismatch_count);
    end
    reset = 1'b0; #1;
    checks++;
    if ({done, pass, fail, timeout} !== 4'b0000 || cycle_count !== 32'd0 ||
        mismatch_count !== 6'd0 || first_mismatch_addr !== 5'd0) begin
      errors++; $display("FAIL abort_outputs: flags=%b cyc=%0d mis=%0d first=%0d, required all 0",
                         {done, pass, fail, timeout}, cycle_count, mismatch_count, first_mismatch_addr);
    end
    checks++;
    if (cif.core_hold !== 1'b1 || cif.reg_addr !== 5'd0) begin
      errors++; $display("FAIL abort_core: hold=%b reg_addr=%0d, required 1/0",
                         cif.core_hold, cif.reg_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    run(20, 1'b0, hl, ma, fin);
    checks++;
    if ({done, pass, fail} !== 3'b110) begin
      errors++; $display("FAIL abort_cleared_table: flags=%b, required 110", {done, pass, fail});
    end
    core_regs[2] = 32'h1234_5678;
    write_exp(1, core_regs[1]); write_exp(2, core_regs[2]); write_exp(3, core_regs[3]);
    run(20, 1'b0, hl, ma, fin);
    checks++;
    if ({done, pass, fail} !== 3'b110 || mismatch_count !== 6'd0) begin
      errors++; $display("FAIL abort_rerun: flags=%b mis=%0d, required 110/0",
                         {done, pass, fail}, mismatch_count);
    end
  endtask

  task automatic test_random();
    int hl, ma, cnt, first, dat; bit fin;
    for (int it = 0; it < 6; it++) begin
      fill_garbage();
      for (int k = 0; k < int'($urandom_range(1, 10)); k++)
        write_exp(int'($urandom_range(0, 31)), $urandom);
      for (int i = 0; i < NREG; i++)
        if (exp_v[i] && $urandom_range(0, 1) == 1) core_regs[i] = exp_m[i];
      // first iteration lands core_done on the last pre-timeout cycle
      dat = (it == 0) ? TO - 1 : int'($urandom_range(1, 150));
      run(dat, 1'b0, hl, ma, fin);
      model_expect(cnt, first);
      checks++;
      if ({done, pass, fail, timeout} !== {1'b1, cnt == 0, cnt != 0, 1'b0} ||
          cycle_count !== 32'(dat)) begin
        errors++; $display("FAIL rand%0d_flags: flags=%b cyc=%0d, required %b/%0d", it,
                           {done, pass, fail, timeout}, cycle_count,
                           {1'b1, cnt == 0, cnt != 0, 1'b0}, dat);
      end
      checks++;
      if (mismatch_count !== 6'(cnt) || first_mismatch_addr !== 5'(first)) begin
        errors++; $display("FAIL rand%0d_counts: mis=%0d first=%0d, required %0d/%0d", it,
                           mismatch_count, first_mismatch_addr, cnt, first);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin core_regs[i] = '0; exp_m[i] = '0; end
    model_clear();
    test_reset();
    test_pass();
    test_back_to_back();
    test_mismatch();
    test_timeout();
    test_sparse();
    test_reset_mid_dump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule

// File: doc/tomasulo_run_harness.md
Name: tomasulo_run_harness

Overview:
- Parametrised run controller and self-check block for the Tomasulo core, the successor to the bare simulation top that only exposed the core's done flag.
- Sits beside the core in the test top. It gates core execution, counts cycles and enforces a timeout watchdog.
- After completion it drains the core, dumps architectural registers through the core's register read port and compares them against a loadable expected table.
- Reports pass, fail or timeout with a mismatch count and the first mismatching register.

Parameters:
- XLEN, 32, register data width.
- REG_ADDR_W, 5, core register address width.
- NUM_CHECK_REGS, 32, registers dumped and checked (1..2**REG_ADDR_W). Indices 0..NUM_CHECK_REGS-1.
- CNT_W, 32, cycle counter width.
- TIMEOUT_CYCLES, 100000, RUN cycles before timeout (must be < 2**CNT_W).
- DRAIN_CYCLES, 8, idle cycles after core done before the dump.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a run (pulse).
- exp_we  in  1  expected-table write enable.
- exp_addr  in  REG_ADDR_W  expected-table index.
- exp_data  in  XLEN  expected value.
- core_hold  out  1  high holds the core in reset/stall.
- core_done  in  1  core program-complete flag.
- reg_addr  out  REG_ADDR_W  core register read address.
- reg_data  in  XLEN  core register read data, combinational from reg_addr.
- done  out  1  run finished (any outcome).
- pass  out  1  finished, no timeout, zero mismatches.
- fail  out  1  finished with mismatch or timeout.
- timeout  out  1  watchdog fired.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- mismatch_count  out  REG_ADDR_W+1  number of mismatching checked registers.
- first_mismatch_addr  out  REG_ADDR_W  index of the first mismatch; 0 if none.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE.
  - core_hold=1.
  - reg_addr, done, pass, fail, timeout, cycle_count, mismatch_count, first_mismatch_addr all 0.
  - All expected-table valid bits cleared.
- FSM states: IDLE, RUN, DRAIN, DUMP, CHECK_LAST, FINISH.
- IDLE:
  - exp_we writes exp_data to entry exp_addr and sets its valid bit. Writes with exp_addr >= NUM_CHECK_REGS are ignored.
  - start -> RUN. Clears cycle_count, mismatch_count, first_mismatch_addr and all result flags.
- exp_we is ignored in every state except IDLE and FINISH.
- RUN:
  - core_hold=0.
  - cycle_count increments each cycle.
  - core_done=1 -> DRAIN.
  - Else, when cycle_count reaches TIMEOUT_CYCLES-1 -> FINISH with timeout=1.
  - core_done and timeout in the same cycle: done takes priority, go to DRAIN.
- DRAIN:
  - core_hold=0. The core keeps running so stores and commits settle; cycle_count is frozen.
  - Down-counter DRAIN_CYCLES; on expiry -> DUMP with index 0.
  - DRAIN_CYCLES=0 goes directly to DUMP.
- DUMP:
  - core_hold=1 freezes the core.
  - reg_addr=index; reg_data is registered the same cycle together with the index.
  - The compare happens one cycle later on the registered pair, so compare latency is 1.
  - Index increments each cycle; after index NUM_CHECK_REGS-1 -> CHECK_LAST to compare the final pipelined entry.
- Compare rule:
  - An entry is checked only if its valid bit is set.
  - A mismatch increments mismatch_count.
  - first_mismatch_addr is captured on the first mismatch only.
  - Unloaded entries are never mismatches.
- CHECK_LAST -> FINISH:
  - done=1.
  - pass=(mismatch_count==0 after final compare) and !timeout.
  - fail=!pass.
- FINISH:
  - Outputs held stable; core_hold=1.
  - start -> RUN with counters and flags cleared; the expected table is retained. The table may be rewritten in FINISH.
- start outside IDLE/FINISH is ignored.
- Reset asserted mid-run aborts immediately; behaviour is identical to power-on reset.
- cycle_count never wraps; the timeout bounds it.

Decomposition:
- Package tomasulo_harness_pkg:
  - harness_state_e enum.
  - Default widths XLEN=32, REG_ADDR_W=5.
  - Timeout default constant.
- Sub-module harness_exp_table:
  - NUM_CHECK_REGS x XLEN storage with per-entry valid bits.
  - Synchronous write, combinational read.
  - Async active-low clear of the valid bits only.
- FSM, counters and compare pipeline live in the top module.

Test Plan:
- Load entries 1=5, 2=10, 3=15; core model asserts core_done at RUN cycle 40; reg_data matches -> done=1, pass=1, cycle_count=40, mismatch_count=0.
- Same setup with reg 2 returning 11 and reg 3 returning 0 -> fail=1, mismatch_count=2, first_mismatch_addr=2.
- core_done never asserted, TIMEOUT_CYCLES=200 -> FINISH after 200 RUN cycles; timeout=1, fail=1, cycle_count=199, no DUMP (reg_addr stays 0).
- Only entry 7 loaded; all other reg_data garbage, reg 7 correct -> pass=1. Also check exp_we during RUN is ignored.
- reset pulled low during DUMP at index 12 -> all outputs 0 immediately and core_hold=1. Then reload the table and start -> clean run passes.
- After a pass, start again in FINISH without reloading -> second identical run passes. cycle_count restarts from 0.
